stack_queue: RTL and testbench

Parametrised single-clock buffer that stores WIDTH-bit words and returns them in FIFO or LIFO order, selectable at run time. It is the successor to the fixed-order stack: same four-phase tx/rx handshakes and full/empty indicators, plus configurable depth and width, occupancy count, almost-full/almost-empty flags and asynchronous reset. It sits between any producer and consumer that use the team's rdy/done handshake.

---
 rtl/stack_queue_pkg.sv | 18 +
 rtl/stack_queue_mem.sv | 27 ++
 rtl/stack_queue.sv | 169 ++++++++++++++++
 tb/tb_stack_queue.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_queue_pkg.sv
// Shared types and constants for the stack_queue FIFO/LIFO buffer.
package stack_queue_pkg;

    typedef enum logic {
        TX_IDLE,
        TX_ACK
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT,
        RX_ACK
    } rx_state_e;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LIFO = 1'b1;

endpackage

// File: rtl/stack_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational
// read port, so a same-address read in the write cycle returns the old word.
module stack_queue_mem #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; count and pointers define which words are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/stack_queue.sv
// Run-time selectable FIFO/LIFO buffer with tx/rx four-phase handshakes.
// Define STACK_QUEUE_FLUSH_EN to add a synchronous flush input.
module stack_queue
    import stack_queue_pkg::*;
#(
    parameter int DEPTH    = 5,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef STACK_QUEUE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       mode,
    input  logic                       tx_rdy,
    output logic                       tx_done,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       rx_rdy,
    input  logic                       rx_done,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       mode_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    tx_state_e        tx_state_q;
    rx_state_e        rx_state_q;
    logic             tx_done_q, rx_rdy_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d, rd_data;
    logic             mode_d;
    logic             flush_w, push_ack, push, pop, switch_mode;
    logic [PTR_W-1:0] wr_base, rd_base, back_m1, mem_waddr, mem_raddr;

`ifdef STACK_QUEUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push_ack    = (tx_state_q == TX_IDLE) && tx_rdy && !full;
        push        = push_ack && !flush_w;
        pop         = (rx_state_q == RX_IDLE) && !empty && !rx_done && !flush_w;
        switch_mode = empty && (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE)
                      && (mode != mode_q);
        mode_d      = switch_mode ? mode : mode_q;
        wr_base     = switch_mode ? '0 : wr_ptr_q;
        rd_base     = switch_mode ? '0 : rd_ptr_q;
        back_m1     = PTR_W'(count_q - 1'b1);

        // In LIFO order count is the stack top; a coincident push refills the popped slot.
        if (mode_d == MODE_LIFO) begin
            mem_raddr = back_m1;
            mem_waddr = pop ? back_m1 : PTR_W'(count_q);
        end else begin
            mem_raddr = rd_base;
            mem_waddr = wr_base;
        end

        wr_ptr_d = wr_base;
        rd_ptr_d = rd_base;
        if (mode_d == MODE_FIFO) begin
            if (push) wr_ptr_d = next_ptr(wr_base);
            if (pop)  rd_ptr_d = next_ptr(rd_base);
        end

        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        if (flush_w) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        out_data_d = pop ? rd_data : out_data_q;
    end

    stack_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (mem_waddr),
        .wdata (in_data),
        .raddr (mem_raddr),
        .rdata (rd_data)
    );

    // NOTE: sequential state uses <= only; = stays in the always_comb next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
            mode_q     <= MODE_FIFO;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
            mode_q     <= mode_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_done_q  <= 1'b0;
        end else if (tx_state_q == TX_IDLE) begin
            if (push_ack) begin
                tx_done_q  <= 1'b1;
                tx_state_q <= TX_ACK;
            end
        end else if (!tx_rdy) begin
            tx_done_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_rdy_q   <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: if (pop) begin
                    rx_rdy_q   <= 1'b1;
                    rx_state_q <= RX_WAIT;
                end
                RX_WAIT: if (rx_done) begin
                    rx_rdy_q   <= 1'b0;
                    rx_state_q <= RX_ACK;
                end
                RX_ACK:  if (!rx_done) rx_state_q <= RX_IDLE;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign tx_done  = tx_done_q;
    assign rx_rdy   = rx_rdy_q;
    assign out_data = out_data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_stack_queue.sv
// Directed self-checking bench for stack_queue (DEPTH=5, WIDTH=8); exercises
// flush as well when STACK_QUEUE_FLUSH_EN is defined.
module tb_stack_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       tx_rdy = 1'b0;
    logic       rx_done = 1'b1;
    logic [7:0] in_data = '0;
    logic       tx_done, rx_rdy, empty, full, almost_full, almost_empty, mode_q;
    logic [7:0] out_data;
    logic [2:0] count;
`ifdef STACK_QUEUE_FLUSH_EN
    logic       flush = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    stack_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef STACK_QUEUE_FLUSH_EN
        .flush        (flush),
`endif
        .mode         (mode),
        .tx_rdy       (tx_rdy),
        .tx_done      (tx_done),
        .in_data      (in_data),
        .rx_rdy       (rx_rdy),
        .rx_done      (rx_done),
        .out_data     (out_data),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .mode_q       (mode_q)
    );

    always #5 clk = ~clk;

    // {tx_done, rx_rdy, empty, full, almost_full, almost_empty, mode_q}
    function automatic logic [6:0] status();
        return {tx_done, rx_rdy, empty, full, almost_full, almost_empty, mode_q};
    endfunction

    task automatic wait_tx(input logic v, input string nm);
        int k = 0;
        while (tx_done !== v && k < 20) begin @(negedge clk); k++; end
        if (tx_done !== v) begin
            $display("FAIL %s: tx_done timeout, got %b want %b", nm, tx_done, v); n_err++;
        end
        n_vec++;
    endtask

    task automatic wait_rx(input logic v, input string nm);
        int k = 0;
        while (rx_rdy !== v && k < 20) begin @(negedge clk); k++; end
        if (rx_rdy !== v) begin
            $display("FAIL %s: rx_rdy timeout, got %b want %b", nm, rx_rdy, v); n_err++;
        end
        n_vec++;
    endtask

    task automatic do_push(input logic [7:0] d);
        tx_rdy = 1'b1; in_data = d;
        wait_tx(1'b1, "push_ack");
        tx_rdy = 1'b0;
        wait_tx(1'b0, "push_release");
    endtask

    task automatic do_read(input logic [7:0] exp, input string nm);
        rx_done = 1'b0;
        wait_rx(1'b1, nm);
        if (out_data !== exp) begin
            $display("FAIL %s: out_data got %0h want %0h", nm, out_data, exp); n_err++;
        end
        n_vec++;
        rx_done = 1'b1;
        wait_rx(1'b0, nm);
    endtask

    // Bring the RX FSM back to idle with rx_done held high (buffer must be empty).
    task automatic rx_park();
        rx_done = 1'b0;
        @(negedge clk);
        rx_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (status() !== 7'b0010010) begin
            $display("FAIL reset_flags: got %b want 0010010", status()); n_err++;
        end
        n_vec++;
        if (count !== 3'd0 || out_data !== 8'h00) begin
            $display("FAIL reset_data: count %0d out %0h want 0 0", count, out_data); n_err++;
        end
        n_vec++;
        rst_n = 1'b1;
        @(negedge clk);
        if (status() !== 7'b0010010) begin
            $display("FAIL post_reset_flags: got %b want 0010010", status()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_fifo();
        do_push(8'd10); do_push(8'd20); do_push(8'd30);
        if (count !== 3'd3 || empty !== 1'b0 || almost_empty !== 1'b0) begin
            $display("FAIL fifo_count3: count %0d empty %b ae %b want 3 0 0", count, empty, almost_empty); n_err++;
        end
        n_vec++;
        do_read(8'd10, "fifo_rd0");
        if (count !== 3'd2) begin $display("FAIL fifo_count2: got %0d want 2", count); n_err++; end
        n_vec++;
        do_read(8'd20, "fifo_rd1");
        if (count !== 3'd1 || almost_empty !== 1'b1) begin
            $display("FAIL fifo_count1: count %0d ae %b want 1 1", count, almost_empty); n_err++;
        end
        n_vec++;
        do_read(8'd30, "fifo_rd2");
        if (count !== 3'd0 || empty !== 1'b1) begin
            $display("FAIL fifo_empty: count %0d empty %b want 0 1", count, empty); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_lifo();
        mode = 1'b1;
        rx_park();
        if (mode_q !== 1'b1) begin $display("FAIL lifo_mode: got %b want 1", mode_q); n_err++; end
        n_vec++;
        do_push(8'd10); do_push(8'd20); do_push(8'd30);
        do_read(8'd30, "lifo_rd0");
        do_read(8'd20, "lifo_rd1");
        do_read(8'd10, "lifo_rd2");
    endtask

    task automatic test_full();
        mode = 1'b0;
        rx_park();
        if (mode_q !== 1'b0) begin $display("FAIL full_mode: got %b want 0", mode_q); n_err++; end
        n_vec++;
        for (int i = 1; i <= 4; i++) do_push(8'(i));
        if (count !== 3'd4 || almost_full !== 1'b1 || full !== 1'b0) begin
            $display("FAIL full_af: count %0d af %b full %b want 4 1 0", count, almost_full, full); n_err++;
        end
        n_vec++;
        do_push(8'd5);
        if (count !== 3'd5 || full !== 1'b1) begin
            $display("FAIL full_5: count %0d full %b want 5 1", count, full); n_err++;
        end
        n_vec++;
        tx_rdy = 1'b1; in_data = 8'h66;
        repeat (3) @(negedge clk);
        if (tx_done !== 1'b0 || count !== 3'd5) begin
            $display("FAIL full_stall: tx_done %b count %0d want 0 5", tx_done, count); n_err++;
        end
        n_vec++;
        do_read(8'd1, "full_rd0");
        wait_tx(1'b1, "full_late_ack");
        tx_rdy = 1'b0;
        wait_tx(1'b0, "full_late_release");
        if (count !== 3'd5 || full !== 1'b1) begin
            $display("FAIL full_refill: count %0d full %b want 5 1", count, full); n_err++;
        end
        n_vec++;
        for (int i = 2; i <= 5; i++) do_read(8'(i), "full_drain");
        do_read(8'h66, "full_wrap");
        if (status() !== 7'b0010010) begin
            $display("FAIL full_drained: got %b want 0010010", status()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_back_to_back();
        mode = 1'b1;
        rx_park();
        do_push(8'hA1); do_push(8'hB2);
        if (count !== 3'd2 || almost_empty !== 1'b0) begin
            $display("FAIL b2b_pre: count %0d ae %b want 2 0", count, almost_empty); n_err++;
        end
        n_vec++;
        tx_rdy = 1'b1; in_data = 8'hC3; rx_done = 1'b0;
        @(negedge clk);
        if (rx_rdy !== 1'b1 || tx_done !== 1'b1 || out_data !== 8'hB2 || count !== 3'd2) begin
            $display("FAIL b2b_same_cycle: rx_rdy %b tx_done %b out %0h count %0d want 1 1 b2 2",
                     rx_rdy, tx_done, out_data, count); n_err++;
        end
        n_vec++;
        tx_rdy = 1'b0; rx_done = 1'b1;
        @(negedge clk);
        if (rx_rdy !== 1'b0 || tx_done !== 1'b0 || count !== 3'd2) begin
            $display("FAIL b2b_release: rx_rdy %b tx_done %b count %0d want 0 0 2", rx_rdy, tx_done, count); n_err++;
        end
        n_vec++;
        do_read(8'hC3, "b2b_rd_c");
        do_read(8'hA1, "b2b_rd_a");
    endtask

    task automatic test_mode_hold();
        do_push(8'h11); do_push(8'h22);
        mode = 1'b0;
        repeat (2) @(negedge clk);
        if (mode_q !== 1'b1) begin $display("FAIL mode_hold_busy: got %b want 1", mode_q); n_err++; end
        n_vec++;
        do_read(8'h22, "mode_hold_rd0");
        do_read(8'h11, "mode_hold_rd1");
        if (mode_q !== 1'b1) begin $display("FAIL mode_hold_rxack: got %b want 1", mode_q); n_err++; end
        n_vec++;
        rx_park();
        if (mode_q !== 1'b0) begin $display("FAIL mode_switch: got %b want 0", mode_q); n_err++; end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) do_push(8'(i));
        rx_done = 1'b0;
        wait_rx(1'b1, "rst_mid_present");
        if (count !== 3'd3 || out_data !== 8'd1) begin
            $display("FAIL rst_mid_pre: count %0d out %0h want 3 1", count, out_data); n_err++;
        end
        n_vec++;
        rst_n = 1'b0;
        #1;
        if (rx_rdy !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || out_data !== 8'h00) begin
            $display("FAIL rst_mid_async: rx_rdy %b count %0d empty %b out %0h want 0 0 1 0",
                     rx_rdy, count, empty, out_data); n_err++;
        end
        n_vec++;
        rx_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_push(8'h09);
        do_read(8'h09, "rst_mid_recover");
    endtask

`ifdef STACK_QUEUE_FLUSH_EN
    task automatic test_flush();
        rx_park();
        for (int i = 1; i <= 4; i++) do_push(8'(i + 16));
        if (count !== 3'd4) begin $display("FAIL flush_pre: got %0d want 4", count); n_err++; end
        n_vec++;
        flush = 1'b1; tx_rdy = 1'b1; in_data = 8'h77;
        @(negedge clk);
        flush = 1'b0;
        if (count !== 3'd0 || empty !== 1'b1 || tx_done !== 1'b1 || rx_rdy !== 1'b0) begin
            $display("FAIL flush_now: count %0d empty %b tx_done %b rx_rdy %b want 0 1 1 0",
                     count, empty, tx_done, rx_rdy); n_err++;
        end
        n_vec++;
        tx_rdy = 1'b0; rx_done = 1'b0;
        repeat (3) @(negedge clk);
        if (rx_rdy !== 1'b0 || tx_done !== 1'b0 || count !== 3'd0) begin
            $display("FAIL flush_after: rx_rdy %b tx_done %b count %0d want 0 0 0", rx_rdy, tx_done, count); n_err++;
        end
        n_vec++;
        rx_done = 1'b1;
        @(negedge clk);
        do_push(8'h5A);
        do_read(8'h5A, "flush_recover");
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fifo();
        test_lifo();
        test_full();
        test_back_to_back();
        test_mode_hold();
        test_reset_mid();
`ifdef STACK_QUEUE_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
